// File: rtl/store_buffer_pkg.sv
// Shared DM access codes, store-buffer entry layout and the helper that
// turns a store request into a lane-aligned entry.
package store_buffer_pkg;

  typedef logic [2:0] dm_op_t;

  localparam dm_op_t DM_w  = 3'd0;
  localparam dm_op_t DM_h  = 3'd1;
  localparam dm_op_t DM_hu = 3'd2;
  localparam dm_op_t DM_b  = 3'd3;
  localparam dm_op_t DM_bu = 3'd4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } sb_entry_t;

  // Data is replicated across lanes so the entry can be written as-is.
  function automatic sb_entry_t make_entry(input dm_op_t op, input logic [31:0] addr,
                                           input logic [31:0] wdata);
    sb_entry_t e;
    e.waddr = addr[31:2];
    case (op)
      DM_h, DM_hu: begin
        e.be   = addr[1] ? 4'b1100 : 4'b0011;
        e.data = {2{wdata[15:0]}};
      end
      DM_b, DM_bu: begin
        e.be   = 4'b0001 << addr[1:0];
        e.data = {4{wdata[7:0]}};
      end
      default: begin
        e.be   = 4'b1111;
        e.data = wdata;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and DM-side signals of the store buffer.
// Handshake: an operation with mem_valid=1 is taken at the rising edge unless
// stall=1, in which case the pipeline holds all mem_* inputs unchanged.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic        mem_valid;
  logic        mem_we;
  dm_op_t      mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        addr_err;
  logic        empty;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport slave (
    input  mem_valid, mem_we, mem_op, mem_addr, mem_wdata, dm_ready, dm_rdata,
    output mem_rdata, stall, addr_err, empty, dm_addr, dm_we, dm_be, dm_wdata
  );

  modport master (
    output mem_valid, mem_we, mem_op, mem_addr, mem_wdata, dm_ready, dm_rdata,
    input  mem_rdata, stall, addr_err, empty, dm_addr, dm_we, dm_be, dm_wdata
  );

endinterface

// File: rtl/store_buffer_load_ext.sv
// Selects the addressed byte/halfword of a merged load word and applies
// sign or zero extension.
module store_buffer_load_ext
  import store_buffer_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  dm_op_t      op,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half   = addr_lo[1] ? word[31:16] : word[15:0];
    byte_v = word[8*addr_lo +: 8];
    result = '0;
    case (op)
      DM_w:    result = word;
      DM_h:    result = {{16{half[15]}}, half};
      DM_hu:   result = {16'h0000, half};
      DM_b:    result = {{24{byte_v[7]}}, byte_v};
      DM_bu:   result = {24'h000000, byte_v};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order posted-store FIFO in front of the data memory; loads read the DM
// in the same cycle and merge any younger bytes still waiting in the FIFO.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t         fifo_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;

  sb_entry_t         head;
  logic              op_known, load_req, is_load, is_store, load_go;
  logic              full, drain, push;
  logic [31:0]       merged, ext;

  assign head     = fifo_q[head_q];
  assign op_known = (bus.mem_op <= DM_bu);
  assign bus.addr_err = bus.mem_valid &&
                        (((bus.mem_op == DM_w) && (bus.mem_addr[1:0] != 2'b00)) ||
                         (((bus.mem_op == DM_h) || (bus.mem_op == DM_hu)) && bus.mem_addr[0]));

  assign load_req = bus.mem_valid && !bus.mem_we && !bus.addr_err;
  assign is_load  = load_req && op_known;
  assign is_store = bus.mem_valid && bus.mem_we && !bus.addr_err && op_known;
  assign load_go  = is_load && bus.dm_ready;

  assign bus.empty = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  // Reset suppresses the drain so no pending entry reaches the DM.
  assign drain     = !reset && !bus.empty && bus.dm_ready && !load_req;
  assign push      = is_store && (!full || drain);
  assign bus.stall = !reset && ((is_store && full && !drain) || (is_load && !bus.dm_ready));

  always_comb begin
    bus.dm_we    = 1'b0;
    bus.dm_be    = 4'b0000;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    if (load_go) begin
      bus.dm_addr = {bus.mem_addr[31:2], 2'b00};
    end else if (drain) begin
      bus.dm_we    = 1'b1;
      bus.dm_be    = head.be;
      bus.dm_addr  = {head.waddr, 2'b00};
      bus.dm_wdata = head.data;
    end
  end

  // Walk oldest to youngest so the youngest matching byte lands last.
  always_comb begin
    merged = bus.dm_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (fifo_q[head_q + PW'(i)].waddr == bus.mem_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (fifo_q[head_q + PW'(i)].be[b])
            merged[8*b +: 8] = fifo_q[head_q + PW'(i)].data[8*b +: 8];
        end
      end
    end
  end

  store_buffer_load_ext u_load_ext (
    .word    (merged),
    .addr_lo (bus.mem_addr[1:0]),
    .op      (bus.mem_op),
    .result  (ext)
  );

  assign bus.mem_rdata = load_go ? ext : 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)  tail_q <= tail_q + PW'(1);
      if (drain) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= make_entry(bus.mem_op, bus.mem_addr, bus.mem_wdata);
  end

endmodule
